// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds, a read-valid strobe and sticky overflow/underflow errors.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign full_fifo         = (fill_count == DEPTH_CNT);
    assign empty_fifo        = (fill_count == '0);
    assign almost_full_fifo  = (fill_count >= umbral_af);
    assign almost_empty_fifo = (fill_count <= umbral_ae);

    // A write into a full FIFO is only safe when a read frees the same slot this edge.
    assign wr_acc  = wr_enable && (!full_fifo || rd_enable);
    assign rd_acc  = rd_enable && !empty_fifo;
    assign ovf_evt = wr_enable && full_fifo && !rd_enable;
    assign unf_evt = rd_enable && empty_fifo;

    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_count    <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + 1'b1;
                2'b01:   fill_count <= fill_count - 1'b1;
                default: fill_count <= fill_count;
            endcase
            // A fresh error event outranks err_clear in the same cycle.
            overflow_err  <= ovf_evt | (overflow_err & ~err_clear);
            underflow_err <= unf_evt | (underflow_err & ~err_clear);
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a default 4-deep/6-bit instance and a 16-deep/16-bit instance
// share one stimulus stream; each is compared every cycle against its own reference queue.
module tb_fifo_param;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        wr_enable;
    logic        rd_enable;
    logic [15:0] din;
    logic [4:0]  thr_af;
    logic [4:0]  thr_ae;
    logic        err_clear;

    logic [5:0]  a_dout;
    logic        a_valid;
    logic [2:0]  a_cnt;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

    logic [15:0] b_dout;
    logic        b_valid;
    logic [4:0]  b_cnt;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] m_dout [2];
    logic        m_valid[2];
    logic        m_ovf  [2];
    logic        m_unf  [2];
    int          b_writes = 0;

    fifo_param dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_enable(wr_enable), .rd_enable(rd_enable),
        .data_in(din[5:0]), .umbral_af(thr_af[2:0]), .umbral_ae(thr_ae[2:0]),
        .err_clear(err_clear),
        .data_out(a_dout), .data_valid(a_valid), .fill_count(a_cnt),
        .full_fifo(a_full), .empty_fifo(a_empty),
        .almost_full_fifo(a_af), .almost_empty_fifo(a_ae),
        .overflow_err(a_ovf), .underflow_err(a_unf)
    );

    fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_enable(wr_enable), .rd_enable(rd_enable),
        .data_in(din), .umbral_af(thr_af), .umbral_ae(thr_ae),
        .err_clear(err_clear),
        .data_out(b_dout), .data_valid(b_valid), .fill_count(b_cnt),
        .full_fifo(b_full), .empty_fifo(b_empty),
        .almost_full_fifo(b_af), .almost_empty_fifo(b_ae),
        .overflow_err(b_ovf), .underflow_err(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [15:0] dout, input logic valid,
                             input logic [4:0] cnt, input logic full, input logic empty,
                             input logic af, input logic ae, input logic ovf, input logic unf);
        int    sz;
        int    depth;
        int    taf;
        int    tae;
        string p;
        p     = (k == 0) ? "a." : "b.";
        sz    = (k == 0) ? q_a.size() : q_b.size();
        depth = (k == 0) ? 4 : 16;
        taf   = (k == 0) ? int'(thr_af[2:0]) : int'(thr_af);
        tae   = (k == 0) ? int'(thr_ae[2:0]) : int'(thr_ae);
        chk({p, "data_valid"}, 32'(valid), 32'(m_valid[k]));
        chk({p, "data_out"},   32'(dout),  32'(m_dout[k]));
        chk({p, "fill_count"}, 32'(cnt),   32'(sz));
        chk({p, "full"},       32'(full),  32'(sz == depth));
        chk({p, "empty"},      32'(empty), 32'(sz == 0));
        chk({p, "almost_full"},  32'(af),  32'(sz >= taf));
        chk({p, "almost_empty"}, 32'(ae),  32'(sz <= tae));
        chk({p, "overflow_err"}, 32'(ovf), 32'(m_ovf[k]));
        chk({p, "underflow_err"}, 32'(unf), 32'(m_unf[k]));
    endtask

    // Advance one clock: update both reference models from the inputs seen at this edge,
    // then compare every output shortly after the edge.
    task automatic tick();
        int          sz;
        int          depth;
        bit          full, empty, wa, ra;
        logic [15:0] wd;
        for (int k = 0; k < 2; k++) begin
            sz    = (k == 0) ? q_a.size() : q_b.size();
            depth = (k == 0) ? 4 : 16;
            wd    = (k == 0) ? (din & 16'h003F) : din;
            if (reset) begin
                if (k == 0) q_a.delete(); else q_b.delete();
                m_dout[k]  = '0;
                m_valid[k] = 1'b0;
                m_ovf[k]   = 1'b0;
                m_unf[k]   = 1'b0;
            end else if (flush) begin
                if (k == 0) q_a.delete(); else q_b.delete();
                m_valid[k] = 1'b0;
            end else begin
                full  = (sz == depth);
                empty = (sz == 0);
                wa    = wr_enable && (!full || rd_enable);
                ra    = rd_enable && !empty;
                m_ovf[k]   = (wr_enable && full && !rd_enable) || (m_ovf[k] && !err_clear);
                m_unf[k]   = (rd_enable && empty) || (m_unf[k] && !err_clear);
                m_valid[k] = ra;
                if (ra) m_dout[k] = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                if (wa) begin
                    if (k == 0) q_a.push_back(wd); else q_b.push_back(wd);
                    if (k == 1) b_writes++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_dut(0, {10'b0, a_dout}, a_valid, {2'b0, a_cnt}, a_full, a_empty, a_af, a_ae, a_ovf, a_unf);
        check_dut(1, b_dout, b_valid, b_cnt, b_full, b_empty, b_af, b_ae, b_ovf, b_unf);
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [15:0] d);
        wr_enable = wr;
        rd_enable = rd;
        din       = d;
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
        din = '0; thr_af = 5'd3; thr_ae = 5'd1; err_clear = 1'b0;
        tick();
        tick();
        chk("reset.empty", 32'(a_empty), 32'd1);
        chk("reset.almost_empty", 32'(a_ae), 32'd1);
        chk("reset.almost_full", 32'(a_af), 32'd0);
        reset = 1'b0;

        // Fill the 4-deep instance, then attempt one write too many.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            if (i == 3) begin
                chk("fill3.almost_full", 32'(a_af), 32'd1);
                chk("fill3.count", 32'(a_cnt), 32'd3);
            end
        end
        chk("fill4.full", 32'(a_full), 32'd1);
        chk("fill4.count", 32'(a_cnt), 32'd4);
        drive(1'b1, 1'b0, 16'h05);
        chk("overflow.set", 32'(a_ovf), 32'd1);
        chk("overflow.count", 32'(a_cnt), 32'd4);

        wr_enable = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Simultaneous read/write while full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'h10 + 16'(i));
            chk("full_rw.valid", 32'(a_valid), 32'd1);
            chk("full_rw.data", 32'(a_dout), (i < 4) ? 32'(i + 1) : 32'(16'h10 + 16'(i - 4)));
        end
        chk("full_rw.count", 32'(a_cnt), 32'd4);
        chk("full_rw.ovf", 32'(a_ovf), 32'd0);
        chk("full_rw.unf", 32'(a_unf), 32'd0);

        // Drain, then read-with-write on empty: no bypass.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0);
        drive(1'b1, 1'b1, 16'h2A);
        chk("nobypass.unf", 32'(a_unf), 32'd1);
        chk("nobypass.valid", 32'(a_valid), 32'd0);
        chk("nobypass.count", 32'(a_cnt), 32'd1);
        drive(1'b0, 1'b1, 16'h0);
        chk("nobypass.read", 32'(a_dout), 32'h2A);
        chk("nobypass.read_valid", 32'(a_valid), 32'd1);

        // Flush preserves data_out and sticky errors.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h30 + 16'(i));
        chk("prefl.count", 32'(a_cnt), 32'd3);
        flush = 1'b1;
        drive(1'b1, 1'b0, 16'h3F);
        flush = 1'b0;
        chk("flush.count", 32'(a_cnt), 32'd0);
        chk("flush.empty", 32'(a_empty), 32'd1);
        chk("flush.dout_held", 32'(a_dout), 32'h2A);
        chk("flush.unf_held", 32'(a_unf), 32'd1);
        wr_enable = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("errclr.unf", 32'(a_unf), 32'd0);
        chk("errclr.ovf", 32'(a_ovf), 32'd0);

        // Threshold corner cases.
        thr_af = 5'd0;
        drive(1'b0, 1'b0, 16'h0);
        chk("thr0.almost_full", 32'(a_af), 32'd1);
        thr_af = 5'd5;
        drive(1'b1, 1'b0, 16'h01);
        chk("thr_hi.almost_full", 32'(a_af), 32'd0);

        // Random traffic, checked mainly on the 16-deep instance across pointer wrap.
        thr_af = 5'd12; thr_ae = 5'd3;
        b_writes = 0;
        for (int n = 0; n < 500 && b_writes < 40; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 16'($urandom));
        end
        chk("random.writes_done", 32'(b_writes >= 40), 32'd1);
        for (int i = 0; i < 18; i++) drive(1'b0, 1'b1, 16'h0);
        chk("random.drained", 32'(b_empty), 32'd1);

        // Reset mid-stream at count 2 with a read pending.
        err_clear = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        err_clear = 1'b0;
        drive(1'b1, 1'b0, 16'h55);
        drive(1'b1, 1'b0, 16'h66);
        chk("prerst.count", 32'(b_cnt), 32'd2);
        reset = 1'b1;
        drive(1'b0, 1'b1, 16'h0);
        reset = 1'b0;
        chk("rst.count", 32'(b_cnt), 32'd0);
        chk("rst.dout", 32'(b_dout), 32'd0);
        chk("rst.valid", 32'(b_valid), 32'd0);
        drive(1'b1, 1'b0, 16'hAA);
        drive(1'b1, 1'b0, 16'hBB);
        drive(1'b0, 1'b1, 16'h0);
        chk("rst.read1", 32'(b_dout), 32'hAA);
        drive(1'b0, 1'b1, 16'h0);
        chk("rst.read2", 32'(b_dout), 32'hBB);
        chk("rst.read2_valid", 32'(b_valid), 32'd1);
        drive(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO for the PCIe transmit-layer data path: the next-generation buffer for the main and per-lane queues. It adds programmable almost-full and almost-empty thresholds, a live occupancy count, correct simultaneous read/write at every fill level, and a read-valid strobe. It also adds sticky overflow and underflow errors and a synchronous flush that does not disturb error state. One clock domain; sits between the upstream producer and the lane distribution logic.

## Interface
- DATA_WIDTH, default 6: word width in bits.
- ADDR_WIDTH, default 2: pointer width. DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous, active-high flush; empties the FIFO but preserves error flags.
- wr_enable  in  1  write request.
- rd_enable  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- umbral_af  in  ADDR_WIDTH+1  almost-full threshold, in words.
- umbral_ae  in  ADDR_WIDTH+1  almost-empty threshold, in words.
- err_clear  in  1  clears the sticky error flags.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  high for one cycle when data_out carries a newly read word.
- fill_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo  out  1 each  status flags.
- overflow_err, underflow_err  out  1 each  sticky error flags.

## Operation
- Priority per cycle: reset > flush > normal operation.
- Write accepted (wr_acc) when wr_enable && (!full_fifo || rd_enable). Writes mem[wr_ptr]; wr_ptr advances by 1 and wraps at DEPTH.
- Read accepted (rd_acc) when rd_enable && !empty_fifo. Registers mem[rd_ptr] into data_out; rd_ptr advances by 1 and wraps.
- No bypass: a read issued while the FIFO is empty is rejected even if a write is accepted in the same cycle.
- fill_count next value:
  - +1 when wr_acc && !rd_acc
  - −1 when rd_acc && !wr_acc
  - unchanged otherwise
  - never exceeds DEPTH and never goes below 0.
- Full with wr_enable and rd_enable both high: both are accepted and the count stays at DEPTH.
- Flags are combinational from the registered fill_count:
  - full_fifo = (fill_count == DEPTH)
  - empty_fifo = (fill_count == 0)
  - almost_full_fifo = (fill_count >= umbral_af)
  - almost_empty_fifo = (fill_count <= umbral_ae); this includes the empty state.
  - A threshold of 0 makes almost_full permanently high. A threshold above DEPTH makes almost_full permanently low.
- overflow_err sets on wr_enable && full_fifo && !rd_enable. The rejected write leaves memory and pointers untouched.
- underflow_err sets on rd_enable && empty_fifo. The rejected read holds data_out and keeps data_valid at 0.
- err_clear clears both error flags. If a new error event occurs in the same cycle as err_clear, the set wins.
- No accepted read: data_out holds its last value and data_valid = 0.
- Reset clears wr_ptr, rd_ptr, fill_count, data_out, data_valid, overflow_err and underflow_err to 0. Memory contents are not reset and are don't-care.
- Flush clears wr_ptr, rd_ptr, fill_count and data_valid. data_out and both error flags hold. wr_enable and rd_enable are ignored that cycle.

## Timing
- Write-to-read latency: a word written at edge N can be read at edge N+1 at the earliest, appearing on data_out with data_valid after edge N+1.
- Read latency: 1 cycle from rd_acc to data_out / data_valid.
- Flags and fill_count update in the cycle after the accepting edge and are glitch-free with respect to clk.
- Reset or flush asserted mid-stream: effective at the next edge. The cycle after, the FIFO reports empty_fifo = 1, fill_count = 0 and data_valid = 0.
- Status outputs after reset:
  - empty_fifo = 1, full_fifo = 0
  - almost_empty_fifo = 1 when umbral_ae >= 0
  - almost_full_fifo = (umbral_af == 0)
- Throughput: one write and one read per cycle, sustained, at any fill level except the blocked cases above.

## Test plan
- Defaults, umbral_af = 3, umbral_ae = 1. Write 0x01..0x04 on consecutive cycles.
  - After the 3rd write: almost_full = 1, count = 3.
  - After the 4th write: full = 1, count = 4.
  - A 5th write without a read sets overflow_err and leaves the contents 0x01..0x04.
- From full, hold rd_enable and wr_enable high for 8 cycles writing 0x10..0x17.
  - data_out returns 0x01..0x04, then 0x10..0x13, with data_valid high every cycle.
  - fill_count stays at 4 and no error flag sets.
- From empty, pulse rd_enable with wr_enable high, data 0x2A.
  - Read is rejected and underflow_err sets.
  - Next cycle count = 1. A following read returns 0x2A with data_valid = 1.
- Fill to 3, then assert flush with wr_enable high.
  - Next cycle count = 0, empty = 1, the last data_out is held, and the sticky errors are unchanged.
  - err_clear then drops both error flags.
- ADDR_WIDTH = 4, DATA_WIDTH = 16. Write and read 40 random words with random enables.
  - Output order matches a reference queue across pointer wrap-around.
  - fill_count tracks the queue depth each cycle.
- Assert reset mid-stream at count 2 with rd_enable high.
  - Next cycle all outputs are at their reset values.
  - Subsequent writes of 0xAA and 0xBB read back in that order.
